vm_change_dispenser: RTL and testbench
======================================

# vm_change_dispenser

Output-side companion to the vending machine controller: consumes its `done`/`product`/`change` completion strobe, buffers completed transactions in a small FIFO, drives the product release motor, and pays out change one coin at a time over a valid/ready handshake to the coin hopper. It sits between the vending machine controller and the physical actuators, so the controller never stalls on slow mechanics.

## Interface
- `DEPTH`, 4, transaction FIFO entries; power of two, at least 2.
- `PULSE_CYCLES`, 3, motor pulse length in clock cycles; at least 1.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `done`  in  1  one-cycle strobe from the controller: the transaction is complete and `product`/`change` are valid.
- `product`  in  2  00 none, 01 chocolate, 10 drink, 11 reserved.
- `change`  in  2  coin units owed, 0–3.
- `coin_ready`  in  1  hopper can eject a coin this cycle.
- `coin_valid`  out  1  request to eject one coin.
- `prod_chock`  out  1  chocolate release motor.
- `prod_drink`  out  1  drink release motor.
- `served`  out  1  one-cycle pulse when a transaction is fully serviced.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `overflow`  out  1  sticky flag: a `done` was dropped; cleared only by `rst`.
- `bad_code`  out  1  sticky flag: a popped entry had product 11; cleared only by `rst`.

## Operation
- FIFO entry is {product, change}, 4 bits. A push happens on any edge where `done`=1 and `full`=0.
- If `done`=1 while `full`=1, the entry is dropped and `overflow` is set. This holds even if a pop happens on the same edge, because `full` is evaluated before the edge.
- Pops happen only from IDLE. Push and pop on the same edge are both performed, and the count is unchanged.
- FSM states: IDLE, RELEASE, PAY, FINISH.
- IDLE: if the FIFO is non-empty, pop into the `cur_prod`/`cur_chg` registers. Next state:
  - RELEASE if product is 01 or 10;
  - else PAY if change is not 0;
  - else FINISH.
  - Product 11 sets `bad_code` and is treated as none.
- RELEASE: the matching motor output is high for exactly `PULSE_CYCLES` cycles, counted by a pulse counter. Then go to PAY if `cur_chg` is not 0, else FINISH. Only one motor is ever high.
- PAY: `coin_valid`=1 continuously. Each edge with `coin_valid`&`coin_ready` decrements `cur_chg`. The handshake that takes `cur_chg` from 1 to 0 moves to FINISH. `coin_valid` never deasserts before a handshake.
- FINISH: `served`=1 for one cycle, then IDLE. FINISH does not pop; the next pop occurs on the following IDLE cycle.
- Change arithmetic: a 2-bit down-counter. Underflow is impossible because PAY is entered only with a non-zero value.
- Reset mid-operation: the FIFO is emptied and the FSM returns to IDLE. Pending motor pulse and coins are abandoned, with no partial payout resumed. All outputs are 0 from the cycle after the reset edge.

## Timing
- Reset values:
  - `coin_valid`, `prod_chock`, `prod_drink`, `served`, `busy`, `full`, `overflow`, `bad_code` = 0;
  - FIFO empty, state IDLE, counters 0.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- Pipeline from `done` sampled at edge E0, with FSM idle and FIFO empty:
  - entry written at E0; `busy`=1 after E0;
  - pop and state change at E1;
  - motor high in the cycles after E1 … E1+`PULSE_CYCLES`;
  - then PAY.
- Each coin costs at least 1 cycle; a stalled `coin_ready` stretches PAY indefinitely.
- Example (defaults, product 01, change 2, `coin_ready` held 1):
  - `prod_chock` high after E1–E4;
  - `coin_valid` high after E4–E6;
  - `served` high after E6;
  - IDLE after E7; `busy` drops after E7 if the FIFO is empty.
- Back-to-back transactions have a minimum gap of 1 IDLE cycle between `served` and the next pop.

## Test plan
- Reset and idle: hold `rst` for 2 cycles, then leave inputs idle for 10 cycles -> all outputs 0, `busy`=0.
- Single vend: `done` with product 01, change 2, `coin_ready`=1 -> `prod_chock` high for exactly 3 cycles, exactly 2 `coin_valid` handshakes, one `served` pulse, matching the E1–E7 timeline.
- Hopper stall: product 10, change 3, `coin_ready` toggles 0,0,1,0,1,1 -> `prod_drink` high for 3 cycles; `coin_valid` stays high until the third accepted coin; exactly 3 handshakes, then `served`.
- Zero-work entries: `done` with product 00, change 0 -> no motor, no `coin_valid`, `served` 1 cycle after the pop. Product 11, change 1 -> `bad_code`=1, no motor, 1 coin paid.
- FIFO full and overflow: five `done` strobes on consecutive cycles while the first is in RELEASE -> `full`=1, `overflow`=1. Exactly 4 `served` pulses in FIFO order, with payouts matching the pushed change values; the 5th entry is lost.
- Reset mid-PAY: assert `rst` after 1 of 3 coins with 2 entries queued -> the next cycle has all outputs 0 and `busy`=0. No further coins, motors or `served` pulses follow, and `overflow`/`bad_code` are cleared.

Source files
------------

// File: rtl/vm_change_dispenser_if.sv
// Bundles the completion strobe coming from the vending machine controller
// with the actuator and hopper signals of the change dispenser.
//   master : controller/hopper side, which drives done, product, change and coin_ready
//   slave  : dispenser side, which drives the motors, the coin request and the status flags
interface vm_change_if;
    logic       done;        // one-cycle completion strobe
    logic [1:0] product;     // 00 none, 01 chocolate, 10 drink, 11 reserved
    logic [1:0] change;      // coin units owed
    logic       coin_ready;  // hopper can eject a coin this cycle
    logic       coin_valid;  // request to eject one coin
    logic       prod_chock;  // chocolate release motor
    logic       prod_drink;  // drink release motor
    logic       served;      // transaction fully serviced
    logic       busy;        // work pending or in progress
    logic       full;        // FIFO holds DEPTH entries
    logic       overflow;    // sticky: a done strobe was dropped
    logic       bad_code;    // sticky: a reserved product code was popped

    modport master (
        output done, product, change, coin_ready,
        input  coin_valid, prod_chock, prod_drink, served, busy, full, overflow, bad_code
    );

    modport slave (
        input  done, product, change, coin_ready,
        output coin_valid, prod_chock, prod_drink, served, busy, full, overflow, bad_code
    );
endinterface

// File: rtl/vm_change_dispenser.sv
// Change dispenser.
// Completed transactions are queued in a small FIFO. An FSM then takes them
// out one at a time, pulses the matching product motor, and pays the change
// out one coin per valid/ready handshake.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : vm_change_if.slave, carrying the strobe/product/change inputs, the
//         hopper handshake, the motor outputs and the status flags
module vm_change_dispenser #(
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    vm_change_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RELEASE, PAY, FINISH} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      prod_reg, prod_next;
    logic [1:0]      chg_reg, chg_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [3:0]      mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            overflow_reg, bad_code_reg;
    logic            full_w, push, pop, bad_set;
    logic [3:0]      head;

    // full comes from the registered count, so a pop on the same edge
    // cannot make room for a strobe that arrives while the FIFO is full.
    assign full_w = (count_reg == DEPTH_C);
    assign push   = bus.done && !full_w;
    assign head   = mem_reg[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        prod_next  = prod_reg;
        chg_next   = chg_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        bad_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop      = 1'b1;
                    chg_next = head[1:0];
                    cnt_next = '0;
                    // The reserved code is flagged and then treated as "no product".
                    if (head[3:2] == 2'b11) begin
                        bad_set   = 1'b1;
                        prod_next = 2'b00;
                    end else begin
                        prod_next = head[3:2];
                    end
                    if (head[3:2] == 2'b01 || head[3:2] == 2'b10)
                        state_next = RELEASE;
                    else if (head[1:0] != 2'd0)
                        state_next = PAY;
                    else
                        state_next = FINISH;
                end
            end
            RELEASE: begin
                if (cnt_reg == PULSE_LAST) begin
                    cnt_next   = '0;
                    state_next = (chg_reg != 2'd0) ? PAY : FINISH;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            PAY: begin
                // PAY is entered only with non-zero change, so this cannot underflow.
                if (bus.coin_ready) begin
                    chg_next = chg_reg - 2'd1;
                    if (chg_reg == 2'd1)
                        state_next = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            prod_reg     <= 2'b00;
            chg_reg      <= 2'd0;
            cnt_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            bad_code_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            prod_reg  <= prod_next;
            chg_reg   <= chg_next;
            cnt_reg   <= cnt_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (bus.done && full_w)
                overflow_reg <= 1'b1;
            if (bad_set)
                bad_code_reg <= 1'b1;
        end
    end

    // FIFO storage has no reset; only the pointers and the count define its contents.
    always_ff @(posedge clk) begin
        if (push)
            mem_reg[wr_ptr_reg] <= {bus.product, bus.change};
    end

    assign bus.coin_valid = (state_reg == PAY);
    assign bus.prod_chock = (state_reg == RELEASE) && (prod_reg == 2'b01);
    assign bus.prod_drink = (state_reg == RELEASE) && (prod_reg == 2'b10);
    assign bus.served     = (state_reg == FINISH);
    assign bus.busy       = (state_reg != IDLE) || (count_reg != '0);
    assign bus.full       = full_w;
    assign bus.overflow   = overflow_reg;
    assign bus.bad_code   = bad_code_reg;
endmodule

// File: tb/tb_vm_change_dispenser.sv
module tb_vm_change_dispenser;
    localparam int PULSE = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vm_change_if bus();

    vm_change_dispenser #(.DEPTH(DEPTH), .PULSE_CYCLES(PULSE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] prod;
        logic [1:0] chg;
        int         chock;
        int         drink;
        int         coins;
        logic       bad;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl [6];
    vec_t mon_e;
    logic [3:0] tl [8];
    logic [7:0] outs;

    int checks = 0;
    int passed = 0;
    int serv_count = 0;
    int hs_total = 0;
    int acc_chock = 0;
    int acc_drink = 0;
    int acc_coins = 0;

    assign outs = {bus.coin_valid, bus.prod_chock, bus.prod_drink, bus.served,
                   bus.busy, bus.full, bus.overflow, bus.bad_code};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t model(input logic [1:0] p, input logic [1:0] c);
        vec_t v;
        v.prod  = p;
        v.chg   = c;
        v.chock = (p == 2'b01) ? PULSE : 0;
        v.drink = (p == 2'b10) ? PULSE : 0;
        v.coins = int'(c);
        v.bad   = (p == 2'b11);
        return v;
    endfunction

    // Scoreboard side: accumulate what the actuators did for the current
    // transaction and compare against the queued expectation on served.
    always @(negedge clk) begin
        if (rst) begin
            acc_chock = 0;
            acc_drink = 0;
            acc_coins = 0;
            exp_q.delete();
        end else begin
            if (bus.prod_chock) acc_chock++;
            if (bus.prod_drink) acc_drink++;
            if (bus.coin_valid && bus.coin_ready) begin
                acc_coins++;
                hs_total++;
            end
            if (bus.served) begin
                serv_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_served", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("chock_cycles", acc_chock, mon_e.chock);
                    chk("drink_cycles", acc_drink, mon_e.drink);
                    chk("coins_paid", acc_coins, mon_e.coins);
                    $display("served prod=%0d chg=%0d chock=%0d drink=%0d coins=%0d",
                             mon_e.prod, mon_e.chg, acc_chock, acc_drink, acc_coins);
                end
                acc_chock = 0;
                acc_drink = 0;
                acc_coins = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.done    = 1'b1;
        bus.product = v.prod;
        bus.change  = v.chg;
        exp_q.push_back(v);
        step();
        bus.done = 1'b0;
    endtask

    task automatic drive_done(input logic [1:0] p, input logic [1:0] c);
        drive_vec(model(p, c));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(bus.busy), 0);
        step();
    endtask

    task automatic wait_cv(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.coin_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(bus.coin_valid), 1);
        step();
    endtask

    initial begin
        logic pat [6];
        int base;
        int n;
        int hs0;

        tbl[0] = '{2'b01, 2'd2, PULSE, 0, 2, 1'b0};
        tbl[1] = '{2'b10, 2'd0, 0, PULSE, 0, 1'b0};
        tbl[2] = '{2'b00, 2'd0, 0, 0, 0, 1'b0};
        tbl[3] = '{2'b00, 2'd3, 0, 0, 3, 1'b0};
        tbl[4] = '{2'b10, 2'd1, 0, PULSE, 1, 1'b0};
        tbl[5] = '{2'b11, 2'd1, 0, 0, 1, 1'b1};

        // {prod_chock, coin_valid, served, busy} after E0..E7 for a 01/2 vend
        tl[0] = 4'b0001; tl[1] = 4'b1001; tl[2] = 4'b1001; tl[3] = 4'b1001;
        tl[4] = 4'b0101; tl[5] = 4'b0101; tl[6] = 4'b0011; tl[7] = 4'b0000;

        pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1;
        pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b1;

        bus.done = 1'b0; bus.product = 2'b00; bus.change = 2'd0; bus.coin_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset and idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle_outputs", int'(outs), 0);
        end
        step();

        // Single vend with exact cycle timeline
        bus.coin_ready = 1'b1;
        drive_done(2'b01, 2'd2);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("vend_timeline_E%0d", k),
                int'({bus.prod_chock, bus.coin_valid, bus.served, bus.busy}), int'(tl[k]));
        end
        step();

        // Table-driven vectors with the hopper always ready
        for (int i = 0; i < 6; i++) begin
            drive_vec(tbl[i]);
            wait_idle("vec_idle", 40);
            chk("vec_bad_code", int'(bus.bad_code), int'(tbl[i].bad));
        end

        // Zero-work entry: served one cycle after the pop
        drive_done(2'b00, 2'd0);
        @(negedge clk); chk("zero_after_E0", int'({bus.served, bus.busy}), 1);
        @(negedge clk); chk("zero_after_E1", int'({bus.served, bus.busy}), 3);
        @(negedge clk); chk("zero_after_E2", int'({bus.served, bus.busy}), 0);
        step();

        // Hopper stall: coin_valid must hold until the third accepted coin
        bus.coin_ready = 1'b0;
        drive_done(2'b10, 2'd3);
        wait_cv("stall_reach_pay", 20);
        for (int i = 0; i < 6; i++) begin
            bus.coin_ready = pat[i];
            @(negedge clk);
            chk("stall_coin_valid_held", int'(bus.coin_valid), 1);
            step();
        end
        bus.coin_ready = 1'b1;
        @(negedge clk);
        chk("stall_served", int'(bus.served), 1);
        step();
        wait_idle("stall_idle", 20);

        // FIFO full and overflow while an earlier entry is stalled in PAY
        bus.coin_ready = 1'b0;
        base = serv_count;
        drive_done(2'b01, 2'd3);
        wait_cv("ovf_reach_pay", 20);
        for (int i = 0; i < 5; i++) begin
            bus.done    = 1'b1;
            bus.product = (i % 2 == 0) ? 2'b10 : 2'b00;
            bus.change  = 2'(i);
            if (i < 4) exp_q.push_back(model(bus.product, bus.change));
            step();
        end
        bus.done = 1'b0;
        @(negedge clk);
        chk("ovf_full", int'(bus.full), 1);
        chk("ovf_overflow", int'(bus.overflow), 1);
        step();
        bus.coin_ready = 1'b1;
        n = 0;
        while (serv_count - base < 5 && n < 200) begin
            step();
            n++;
        end
        wait_idle("ovf_idle", 40);
        chk("ovf_served_count", serv_count - base, 5);
        chk("ovf_queue_empty", exp_q.size(), 0);
        chk("ovf_sticky", int'(bus.overflow), 1);

        // Reset in the middle of PAY with two entries queued
        bus.coin_ready = 1'b0;
        drive_done(2'b01, 2'd3);
        wait_cv("rst_reach_pay", 20);
        drive_done(2'b10, 2'd1);
        drive_done(2'b00, 2'd2);
        hs0 = hs_total;
        bus.coin_ready = 1'b1;
        step();
        bus.coin_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_one_coin_before", hs_total - hs0, 1);
        @(negedge clk);
        chk("rst_outputs_cleared", int'(outs), 0);
        bus.coin_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", int'(outs), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
